fuel_interlock: RTL
===================

Name: fuel_interlock

Overview:
- Parametrised successor to the single-switch fuel-pump anti-theft logic.
- Enables `fuel_pump` only after a multi-bit hidden code plus brake has been held for a minimum time, within a time window after ignition.
- Counts failed attempts and enters a timed lockout after too many failures.
- Sits between the ignition/switch-debounce inputs and the pump relay driver.

Parameters:
- N_SW, 4: number of hidden switch bits.
- CODE, 4'b1010: required hidden_sw pattern (N_SW bits).
- HOLD_CYCLES, 4: consecutive matching samples (brake=1, hidden_sw==CODE) needed to unlock; ≥1.
- WINDOW_CYCLES, 16: edges after arming within which unlock must complete; must exceed HOLD_CYCLES.
- MAX_TRIES, 3: failed attempts that trigger lockout; ≥1.
- LOCKOUT_CYCLES, 32: lockout duration in clock cycles.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- ignition  in  1  ignition key on.
- brake  in  1  brake pedal pressed.
- hidden_sw  in  N_SW  hidden switch bank.
- fuel_pump  out  1  pump enable, registered.
- locked  out  1  high while in LOCKOUT, registered.
- tries_used  out  $clog2(MAX_TRIES+1)  failed attempts since last success/lockout, registered.

Behaviour:
- Reset (reset=0, async): state=IDLE; fuel_pump=0, locked=0, tries_used=0; all counters cleared.
- Define `match` = brake & (hidden_sw==CODE).
- Define `wrong` = brake & (hidden_sw!=CODE) & (hidden_sw!=0).
- All inputs are sampled on the rising edge of clock; every output is a register.
- States: IDLE, ARMED, HOLD, RUN, RETRY, LOCKOUT.
- IDLE:
  - ignition=1 → ARMED; window counter loaded with WINDOW_CYCLES.
- ARMED:
  - window counter decrements each edge.
  - match → HOLD with hold count=1.
  - wrong → fail.
  - ignition=0 → IDLE (no failure counted).
- HOLD:
  - window counter keeps decrementing; it is not reloaded.
  - match → hold count +1.
  - match drops → back to ARMED (hold count cleared).
  - wrong → fail.
  - When the HOLD_CYCLES-th consecutive match is sampled → RUN. fuel_pump rises on that same edge.
  - HOLD_CYCLES=1: ARMED → RUN directly on the first match edge.
- Window expiry: if RUN is not reached by the WINDOW_CYCLES-th edge after arming → fail.
- Fail:
  - tries_used +1.
  - If the new value == MAX_TRIES → LOCKOUT; lockout counter loaded with LOCKOUT_CYCLES; locked=1.
  - Otherwise → RETRY.
- RETRY: waits for ignition=0, then → IDLE. Forces a key cycle before each new attempt.
- RUN:
  - fuel_pump=1; tries_used cleared to 0.
  - brake/hidden_sw ignored.
  - ignition=0 → IDLE; fuel_pump falls on that edge.
- LOCKOUT:
  - all inputs ignored; counter decrements each edge.
  - On expiry → RETRY; locked falls and tries_used clears on that edge.
- Precedence on the same edge: ignition=0 > unlock > wrong/expiry.
  - Success on the final window edge wins over expiry.
  - In LOCKOUT, ignition has no effect.
- tries_used saturates at MAX_TRIES.
- Counters are sized with $clog2(max value + 1) and must not wrap.
- Reset mid-RUN or mid-LOCKOUT: immediate return to reset values; lockout is not persistent across reset.

Optional Feature:
- Macro: FUEL_INTERLOCK_ALARM_EN.
- When defined:
  - Extra output port `alarm` (1 bit, registered, reset 0).
  - alarm is high during LOCKOUT and for the 1 cycle of every fail event, i.e. it pulses on the fail edge.
- When undefined: no `alarm` port and no alarm logic.

Decomposition:
- Shared package `fuel_pkg`:
  - state enum type fuel_state_t (6 states).
  - default parameter constants.
  - width-helper function for counters.
- One sub-module is natural: `down_counter` (parametrised width, load/enable/zero flag), instantiated for the window and lockout counts.
- The hold count stays inline.

Test Plan (defaults; C=1010):
- Happy path:
  - Stimulus: reset pulse; ignition=1; 2 edges later brake=1 and hidden_sw=C held.
  - Required: fuel_pump=1 exactly on the 4th matching edge; tries_used=0.
  - Then ignition=0 → fuel_pump=0 on the next edge.
- Broken hold:
  - Stimulus: match for 3 edges, brake=0 for 1 edge, match again.
  - Required: the hold count restarts; fuel_pump rises after 4 further consecutive matches, all within the window.
- Window expiry:
  - Stimulus: ignition=1, no inputs for 16 edges.
  - Required: tries_used=1; state RETRY. A second attempt is ignored until ignition toggles 0→1.
- Lockout:
  - Stimulus: 3 attempts with brake=1, hidden_sw=0110.
  - Required: on the 3rd wrong edge locked=1 and tries_used=3.
  - A correct code during the following 32 cycles gives no fuel_pump.
  - After 32 cycles locked=0 and tries_used=0.
- Async reset mid-RUN:
  - Stimulus: reset=0 asserted between clock edges while fuel_pump=1.
  - Required: fuel_pump=0 immediately, without waiting for a clock edge.
- Alarm (macro defined):
  - Required: alarm pulses for 1 cycle on the 1st fail, and is held high throughout LOCKOUT.

Source files
------------

// File: rtl/fuel_pkg.sv
// fuel_pkg: shared state type, default parameters and counter width helper for fuel_interlock.
package fuel_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, HOLD, RUN, RETRY, LOCKOUT} fuel_state_t;
  localparam int DEF_N_SW = 4;
  localparam logic [3:0] DEF_CODE = 4'b1010;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_WINDOW_CYCLES = 16;
  localparam int DEF_MAX_TRIES = 3;
  localparam int DEF_LOCKOUT_CYCLES = 32;
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/down_counter.sv
// down_counter: loadable down counter that holds at zero instead of wrapping.
module down_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);
  logic [W-1:0] r_count;
  assign o_zero = r_count == '0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_en && !o_zero) r_count <= r_count - 1'b1;
  end
endmodule

// File: rtl/fuel_interlock.sv
// fuel_interlock: hidden-code + brake hold anti-theft gate for the fuel pump with retry lockout.
// Optional alarm output enabled by defining FUEL_INTERLOCK_ALARM_EN.
module fuel_interlock
  import fuel_pkg::*;
#(
  parameter int              N_SW           = DEF_N_SW,
  parameter logic [N_SW-1:0] CODE           = N_SW'(DEF_CODE),
  parameter int              HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int              WINDOW_CYCLES  = DEF_WINDOW_CYCLES,
  parameter int              MAX_TRIES      = DEF_MAX_TRIES,
  parameter int              LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               ignition,
  input  logic                               brake,
  input  logic [N_SW-1:0]                    hidden_sw,
  output logic                               fuel_pump,
  output logic                               locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_used
`ifdef FUEL_INTERLOCK_ALARM_EN
  ,
  output logic                               alarm
`endif
);
  localparam int WIN_W = cnt_w(WINDOW_CYCLES);
  localparam int LCK_W = cnt_w(LOCKOUT_CYCLES);
  localparam int HLD_W = cnt_w(HOLD_CYCLES);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  fuel_state_t r_state, w_next;
  logic [HLD_W-1:0] r_hold, w_hold_inc;
  logic [TRY_W-1:0] r_tries, w_tries_inc, w_tries_next;
  logic r_pump, r_locked;
  logic w_match, w_wrong, w_in_window, w_unlock, w_fail, w_lock_now;
  logic w_win_zero, w_lck_zero, w_win_last, w_lck_last;
  assign w_match     = brake && hidden_sw == CODE;
  assign w_wrong     = brake && hidden_sw != CODE && hidden_sw != '0;
  assign w_in_window = r_state == ARMED || r_state == HOLD;
  assign w_hold_inc  = (r_state == HOLD ? r_hold : '0) + 1'b1;
  assign w_win_last  = w_in_window && w_win_zero;
  assign w_lck_last  = r_state == LOCKOUT && w_lck_zero;
  assign w_unlock    = w_in_window && ignition && w_match && w_hold_inc == HLD_W'(HOLD_CYCLES);
  assign w_fail      = w_in_window && ignition && !w_unlock && (w_wrong || w_win_last);
  assign w_tries_inc = r_tries == TRY_W'(MAX_TRIES) ? r_tries : r_tries + 1'b1;
  assign w_lock_now  = w_fail && w_tries_inc == TRY_W'(MAX_TRIES);
  assign w_tries_next = (w_unlock || w_lck_last) ? '0 : w_fail ? w_tries_inc : r_tries;
  // Counters load one less than the span so that zero marks the final edge of the span.
  down_counter #(.W(WIN_W)) u_window (
    .clock      (clock),
    .reset      (reset),
    .i_load     (r_state == IDLE && ignition),
    .i_load_val (WIN_W'(WINDOW_CYCLES - 1)),
    .i_en       (w_in_window),
    .o_zero     (w_win_zero)
  );
  down_counter #(.W(LCK_W)) u_lockout (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_lock_now),
    .i_load_val (LCK_W'(LOCKOUT_CYCLES - 1)),
    .i_en       (r_state == LOCKOUT),
    .o_zero     (w_lck_zero)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        w_next = ignition ? ARMED : IDLE;
      ARMED, HOLD: w_next = !ignition ? IDLE : w_unlock ? RUN :
                            w_fail ? (w_lock_now ? LOCKOUT : RETRY) : w_match ? HOLD : ARMED;
      RUN, RETRY:  w_next = ignition ? r_state : IDLE;
      LOCKOUT:     w_next = w_lck_last ? RETRY : LOCKOUT;
      default:     w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_hold   <= '0;
      r_tries  <= '0;
      r_pump   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_hold   <= w_next == HOLD ? w_hold_inc : '0;
      r_tries  <= w_tries_next;
      r_pump   <= w_next == RUN;
      r_locked <= w_next == LOCKOUT;
    end
  end
  assign fuel_pump  = r_pump;
  assign locked     = r_locked;
  assign tries_used = r_tries;
`ifdef FUEL_INTERLOCK_ALARM_EN
  logic r_alarm;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_alarm <= 1'b0;
    else r_alarm <= w_fail || w_next == LOCKOUT;
  end
  assign alarm = r_alarm;
`endif
endmodule
